// File: rtl/seq_trigger_pkg.sv
// Shared definitions for the sequence trigger monitor: FSM state encoding
// and the default activity-register fill constant.
package seq_trigger_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMING = 2'd1,
    FIRED  = 2'd2
  } trig_state_t;

  // ACT_INIT default is this two-bit pair replicated across the register,
  // giving 1010...10 (MSB set).
  localparam logic [1:0] ACT_INIT_PAIR = 2'b10;

endpackage

// File: rtl/seq_trigger_act_reg.sv
// Activity register: loads its init value on reset, rotates right by one
// bit when asked, otherwise holds.
module seq_trigger_act_reg #(
  parameter int unsigned ACT_W = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ACT_W-1:0] init,
  input  logic             rotate,
  output logic [ACT_W-1:0] act
);

  // Load on reset, rotate right while enabled, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      act <= init;
    end else if (rotate) begin
      act <= {act[0], act[ACT_W-1:1]};
    end
  end

endmodule

// File: rtl/seq_trigger_monitor.sv
// Sequence trigger monitor: matches a stream of qualified samples against
// SEQ_LEN live pattern words and raises a registered trigger once the full
// sequence is seen. While fired, the activity register rotates each cycle.
// Optional feature macro: SEQ_TRIGGER_TIMEOUT_EN -- auto-disarm after
// TIMEOUT fired cycles. Without it FIRED is sticky until rst.
module seq_trigger_monitor
  import seq_trigger_pkg::*;
#(
  parameter int unsigned      DATA_W   = 128,
  parameter int unsigned      SEQ_LEN  = 4,
  parameter int unsigned      ACT_W    = 128,
  parameter logic [ACT_W-1:0] ACT_INIT = ACT_W'({ACT_W/2{ACT_INIT_PAIR}}),
  parameter int unsigned      TIMEOUT  = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        state_vld,
  input  logic [DATA_W-1:0]           state,
  input  logic [SEQ_LEN*DATA_W-1:0]   pattern,
  input  logic                        strict,
  output logic [$clog2(SEQ_LEN+1)-1:0] progress,
  output logic                        trig,
  output logic [ACT_W-1:0]            act
);

  localparam int unsigned PW = $clog2(SEQ_LEN + 1);

  if (SEQ_LEN < 1 || SEQ_LEN > 16) begin : g_bad_seq_len
    $error("seq_trigger_monitor: SEQ_LEN out of range 1..16");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("seq_trigger_monitor: TIMEOUT must be at least 1");
  end

  trig_state_t       fsm_q;
  logic [PW-1:0]     progress_q;
  logic              trig_q;
  logic [DATA_W-1:0] cur_word;
  logic [DATA_W-1:0] word0;
  logic              hit_first;

  // Pattern word indexed by current progress; defaults to zero so FIRED
  // (progress == SEQ_LEN) never indexes past the pattern bus.
  always_comb begin
    cur_word = '0;
    for (int unsigned k = 0; k < SEQ_LEN; k++) begin
      if (progress_q == PW'(k)) begin
        cur_word = pattern[k*DATA_W +: DATA_W];
      end
    end
  end

  assign word0     = pattern[DATA_W-1:0];
  assign hit_first = (state == word0);

`ifdef SEQ_TRIGGER_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] tmo_q;
  logic          tmo_hit;

  assign tmo_hit = (fsm_q == FIRED) && (tmo_q == CW'(TIMEOUT - 1));

  // Count FIRED cycles from zero; cleared outside FIRED and on expiry.
  always_ff @(posedge clk) begin
    if (rst || fsm_q != FIRED || tmo_hit) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + CW'(1);
    end
  end
`endif

  // Match FSM: advance on a valid match, restart or hold on a valid
  // mismatch depending on strict, ignore samples once fired.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q      <= IDLE;
      progress_q <= '0;
      trig_q     <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE, ARMING: begin
          if (state_vld) begin
            if (state == cur_word) begin
              if (progress_q == PW'(SEQ_LEN - 1)) begin
                fsm_q      <= FIRED;
                progress_q <= PW'(SEQ_LEN);
                trig_q     <= 1'b1;
              end else begin
                fsm_q      <= ARMING;
                progress_q <= progress_q + PW'(1);
              end
            end else if (strict) begin
              // A restarting sample may itself be the first pattern word.
              if (hit_first) begin
                fsm_q      <= ARMING;
                progress_q <= PW'(1);
              end else begin
                fsm_q      <= IDLE;
                progress_q <= '0;
              end
            end
          end
        end
        FIRED: begin
`ifdef SEQ_TRIGGER_TIMEOUT_EN
          if (tmo_hit) begin
            fsm_q      <= IDLE;
            progress_q <= '0;
            trig_q     <= 1'b0;
          end
`endif
        end
        default: begin
          fsm_q      <= IDLE;
          progress_q <= '0;
          trig_q     <= 1'b0;
        end
      endcase
    end
  end

  seq_trigger_act_reg #(
    .ACT_W (ACT_W)
  ) u_act_reg (
    .clk    (clk),
    .rst    (rst),
    .init   (ACT_INIT),
    .rotate (fsm_q == FIRED),
    .act    (act)
  );

  assign progress = progress_q;
  assign trig     = trig_q;

endmodule

// File: tb/tb_seq_trigger_monitor.sv
// Scoreboard bench for seq_trigger_monitor: the driver pushes the expected
// post-edge outputs per cycle, the monitor pops and compares after each edge.
module tb_seq_trigger_monitor;

  localparam logic [127:0] W0    = 128'h3243f6a8_885a308d_313198a2_e0370734;
  localparam logic [127:0] W1    = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] W2    = 128'h0;
  localparam logic [127:0] W3    = 128'h1;
  localparam logic [127:0] JUNK  = 128'hdeadbeef_0badf00d_cafebabe_12345678;
  localparam logic [127:0] INIT  = {64{2'b10}};
  localparam logic [127:0] ROT   = {64{2'b01}};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         state_vld = 1'b0;
  logic [127:0] state = '0;
  logic         strict = 1'b1;
  logic [511:0] pattern;
  logic [2:0]   progress;
  logic         trig;
  logic [127:0] act;

  logic         rst1 = 1'b1;
  logic         vld1 = 1'b0;
  logic [0:0]   progress1;
  logic         trig1;
  logic [7:0]   act1;

  // Next-cycle controls for the SEQ_LEN=1 instance, latched by step().
  logic n_rst1 = 1'b1;
  logic n_vld1 = 1'b0;
  logic chk_en = 1'b1;

  typedef struct {
    logic         chk;
    logic [2:0]   p;
    logic         t;
    logic         ac;
    logic [127:0] a;
    logic         p1;
    logic         t1;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  int    checks = 0;
  int    errors = 0;

  assign pattern = {W3, W2, W1, W0};

  always #5 clk = ~clk;

  seq_trigger_monitor #(
    .DATA_W (128),
    .SEQ_LEN(4),
    .ACT_W  (128),
    .TIMEOUT(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .state_vld(state_vld),
    .state    (state),
    .pattern  (pattern),
    .strict   (strict),
    .progress (progress),
    .trig     (trig),
    .act      (act)
  );

  seq_trigger_monitor #(
    .DATA_W  (128),
    .SEQ_LEN (1),
    .ACT_W   (8),
    .ACT_INIT(8'ha5),
    .TIMEOUT (8)
  ) dut1 (
    .clk      (clk),
    .rst      (rst1),
    .state_vld(vld1),
    .state    (state),
    .pattern  (W0),
    .strict   (strict),
    .progress (progress1),
    .trig     (trig1),
    .act      (act1)
  );

  task automatic cmp(input string nm, input string fld,
                     input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s.%s got=%h exp=%h", nm, fld, got, exp);
    end
  endtask

  // Drive one cycle's inputs and queue the outputs expected after its edge.
  task automatic step(input string nm, input logic r, input logic v,
                      input logic [127:0] s, input logic st,
                      input logic [2:0] ep, input logic et,
                      input logic ac, input logic [127:0] ea,
                      input logic ep1, input logic et1);
    exp_t e;
    @(negedge clk);
    rst = r; state_vld = v; state = s; strict = st;
    rst1 = n_rst1; vld1 = n_vld1;
    e.chk = chk_en; e.p = ep; e.t = et; e.ac = ac; e.a = ea;
    e.p1 = ep1; e.t1 = et1;
    q.push_back(e);
    nq.push_back(nm);
  endtask

  // Monitor: every edge is an output event; compare against the queue head.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e  = q.pop_front();
        nm = nq.pop_front();
        if (e.chk) begin
          cmp(nm, "progress", 128'(progress), 128'(e.p));
          cmp(nm, "trig", 128'(trig), 128'(e.t));
          if (e.ac) cmp(nm, "act", act, e.a);
          cmp(nm, "progress1", 128'(progress1), 128'(e.p1));
          cmp(nm, "trig1", 128'(trig1), 128'(e.t1));
        end
      end
    end
  end

  initial begin
    logic [2:0]   ep;
    logic         et;
    logic [127:0] ea;

    // Reset state
    step("reset0", 1, 0, '0, 1, 0, 0, 1, INIT, 0, 0);
    step("reset1", 1, 0, '0, 1, 0, 0, 1, INIT, 0, 0);

    // Full sequence, then rotation
    step("seq_w0", 0, 1, W0, 1, 1, 0, 1, INIT, 0, 0);
    step("seq_w1", 0, 1, W1, 1, 2, 0, 1, INIT, 0, 0);
    step("seq_w2", 0, 1, W2, 1, 3, 0, 1, INIT, 0, 0);
    step("seq_w3", 0, 1, W3, 1, 4, 1, 1, INIT, 0, 0);
    step("seq_rot1", 0, 0, '0, 1, 4, 1, 1, ROT, 0, 0);
    step("seq_ign", 0, 1, W0, 0, 4, 1, 1, INIT, 0, 0);

    // Reset while FIRED
    step("rst_fired", 1, 1, W0, 1, 0, 0, 1, INIT, 0, 0);

    // Strict restart behaviour
    step("str_w0", 0, 1, W0, 1, 1, 0, 1, INIT, 0, 0);
    step("str_w1", 0, 1, W1, 1, 2, 0, 1, INIT, 0, 0);
    step("str_junk", 0, 1, JUNK, 1, 0, 0, 1, INIT, 0, 0);
    step("str_w0b", 0, 1, W0, 1, 1, 0, 1, INIT, 0, 0);
    step("str_w0c", 0, 1, W0, 1, 1, 0, 1, INIT, 0, 0);
    step("str_rst", 1, 0, '0, 0, 0, 0, 1, INIT, 0, 0);

    // Non-strict: mismatches ignored
    step("lax_w0", 0, 1, W0, 0, 1, 0, 1, INIT, 0, 0);
    step("lax_w1", 0, 1, W1, 0, 2, 0, 1, INIT, 0, 0);
    step("lax_junk", 0, 1, JUNK, 0, 2, 0, 1, INIT, 0, 0);
    step("lax_w2", 0, 1, W2, 0, 3, 0, 1, INIT, 0, 0);
    step("lax_rst", 1, 0, '0, 1, 0, 0, 1, INIT, 0, 0);

    // Interleaved invalid cycles
    step("gap_w0", 0, 1, W0, 1, 1, 0, 1, INIT, 0, 0);
    step("gap_h1", 0, 0, W1, 1, 1, 0, 1, INIT, 0, 0);
    step("gap_w1", 0, 1, W1, 1, 2, 0, 1, INIT, 0, 0);
    step("gap_h2", 0, 0, JUNK, 1, 2, 0, 1, INIT, 0, 0);
    step("gap_w2", 0, 1, W2, 1, 3, 0, 1, INIT, 0, 0);
    step("gap_h3", 0, 0, W3, 1, 3, 0, 1, INIT, 0, 0);
    step("gap_w3", 0, 1, W3, 1, 4, 1, 1, INIT, 0, 0);
    step("gap_rst", 1, 0, '0, 1, 0, 0, 1, INIT, 0, 0);

    // Reset coincident with the completing match
    step("rc_w0", 0, 1, W0, 1, 1, 0, 1, INIT, 0, 0);
    step("rc_w1", 0, 1, W1, 1, 2, 0, 1, INIT, 0, 0);
    step("rc_w2", 0, 1, W2, 1, 3, 0, 1, INIT, 0, 0);
    step("rc_w3rst", 1, 1, W3, 1, 0, 0, 1, INIT, 0, 0);
    step("rc_after", 0, 0, '0, 1, 0, 0, 1, INIT, 0, 0);

    // Fire, then watch timeout / stickiness
    step("to_w0", 0, 1, W0, 1, 1, 0, 1, INIT, 0, 0);
    step("to_w1", 0, 1, W1, 1, 2, 0, 1, INIT, 0, 0);
    step("to_w2", 0, 1, W2, 1, 3, 0, 1, INIT, 0, 0);
    step("to_w3", 0, 1, W3, 1, 4, 1, 1, INIT, 0, 0);
    for (int i = 1; i <= 9; i++) begin
`ifdef SEQ_TRIGGER_TIMEOUT_EN
      ep = (i < 8) ? 3'd4 : 3'd0;
      et = (i < 8);
      ea = (i >= 8) ? INIT : ((i % 2) ? ROT : INIT);
`else
      ep = 3'd4;
      et = 1'b1;
      ea = (i % 2) ? ROT : INIT;
`endif
      step($sformatf("to_c%0d", i), 0, 0, '0, 1, ep, et, 1, ea, 0, 0);
    end
    chk_en = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step("long", 0, 0, '0, 1, 0, 0, 0, INIT, 0, 0);
    end
    chk_en = 1'b1;
`ifdef SEQ_TRIGGER_TIMEOUT_EN
    step("long_end", 0, 0, '0, 1, 0, 0, 1, INIT, 0, 0);
`else
    step("long_end", 0, 0, '0, 1, 4, 1, 1, INIT, 0, 0);
`endif

    // SEQ_LEN=1 instance; main instance parked in reset
    step("s1_park", 1, 0, '0, 1, 0, 0, 1, INIT, 0, 0);
    n_rst1 = 1'b0; n_vld1 = 1'b1;
    step("s1_junk", 1, 0, JUNK, 1, 0, 0, 1, INIT, 0, 0);
    step("s1_w0", 1, 0, W0, 1, 0, 0, 1, INIT, 1, 1);
    n_vld1 = 1'b0;
    step("s1_hold", 1, 0, JUNK, 1, 0, 0, 1, INIT, 1, 1);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 8 && q.size() != 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
